status_reg_access_ctrl: RTL
===========================

# status_reg_access_ctrl

Sequencer between the I2C slave byte engine and the status register banks (header/ID bank, GPI banks, etc.). Holds an 8-bit register pointer, decodes it into a one-hot port select and one-hot offset select, and runs the read or write strobe cycle. Waits out the bank's registered read latency and returns the read byte to the I2C engine with a valid pulse. It is the only driver of the shared PORT_CS/OFFSET_SEL/RD_WR/DIN bus.

## Interface
- NUM_PORTS, 4: number of register banks; pointer port index 0..NUM_PORTS-1 is valid.
- SYSCLK in 1: system clock, all logic on rising edge.
- RESET in 1: asynchronous, active-high reset.
- CMD_VALID in 1: command byte from I2C engine present.
- CMD_READY out 1: controller accepts the command this cycle.
- CMD_TYPE in 2: 00 set pointer, 01 write, 10 read, 11 reserved.
- CMD_DATA in 8: pointer value (set) or write data (write); ignored for read.
- RSP_VALID out 1: one-cycle pulse, RSP_DATA valid.
- RSP_DATA out 8: read result, held until the next read response.
- PORT_CS out NUM_PORTS: one-hot bank select.
- OFFSET_SEL out 16: one-hot register offset, shared by all banks.
- RD_WR out 1: 1 = read, 0 = write; meaningful only while PORT_CS is non-zero.
- DIN_BUS out 8: write data to banks.
- PORT_DOUT in NUM_PORTS*8: bank read data; bank k occupies bits [8k+7:8k].
- PTR out 8: current pointer.
- ADDR_ERR out 1: sticky error flag.
- ERR_CLR in 1: synchronous clear of ADDR_ERR.

## Operation
- Pointer layout: PTR[7:4] = port index, PTR[3:0] = offset. OFFSET_SEL = 1<<PTR[3:0]. PORT_CS = 1<<PTR[7:4] when index < NUM_PORTS, else 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - CMD_READY = 1 only in IDLE.
  - Accept means CMD_VALID & CMD_READY.
- Set pointer: on accept, PTR <= CMD_DATA; stays in IDLE; no bus activity.
- Read: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
  - ACCESS: PORT_CS, OFFSET_SEL and RD_WR=1 driven for exactly one cycle.
  - WAIT: RSP_DATA <= selected PORT_DOUT slice, or 8'hFF for an invalid port.
  - RESP: RSP_VALID=1.
- Write: IDLE -> ACCESS -> IDLE.
  - ACCESS: PORT_CS, OFFSET_SEL, RD_WR=0 and DIN_BUS=CMD_DATA (captured at accept) driven for one cycle.
  - Invalid port: no PORT_CS asserted, write dropped.
- Invalid port on read or write sets ADDR_ERR. CMD_TYPE 11 is accepted, ignored and sets ADDR_ERR.
- ERR_CLR in the same cycle as a new error: the set wins.
- Outside ACCESS: PORT_CS=0, OFFSET_SEL=0, RD_WR=1, DIN_BUS=0.
- Pointer post-increment after each read/write (see Configuration) is 8-bit modulo: 0x0F -> 0x10 crosses into the next port; 0xFF -> 0x00.

## Timing
- Reset values: CMD_READY=1 (FSM IDLE), RSP_VALID=0, RSP_DATA=0, PORT_CS=0, OFFSET_SEL=0, RD_WR=1, DIN_BUS=0, PTR=0, ADDR_ERR=0.
- Accept at cycle N. All outputs are registered.
  - Read: ACCESS strobe at N+1; bank registers DOUT at end of N+1; sampled at end of N+2; RSP_VALID at N+3. Next accept no earlier than N+4.
  - Write: strobe at N+1. Next accept no earlier than N+2.
  - Set pointer: PTR updated at N+1. Next accept possible at N+1.
- PTR increments on the cycle after ACCESS.
- CMD_VALID held while CMD_READY=0 is not consumed. No command is lost or duplicated.
- RESET asserted mid-transaction: FSM goes to IDLE immediately; any pending RSP_VALID is suppressed; strobes deassert asynchronously.

## Configuration
- STATUS_PTR_AUTOINC_EN defined: PTR increments by 1 after every read or write, including dropped invalid-port accesses.
- STATUS_PTR_AUTOINC_EN undefined: PTR changes only on set-pointer commands or reset.

## Test plan
- Reset, set pointer 0x02, read -> PORT_CS=0001, OFFSET_SEL=0x0004, RD_WR=1 for one cycle; RSP_VALID at accept+3 with RSP_DATA = bank0 byte for offset 2; PTR=0x03 (autoinc on).
- Set pointer 0x1F, write 0xA5 -> PORT_CS=0010, OFFSET_SEL=0x8000, RD_WR=0, DIN_BUS=0xA5 for one cycle; PTR=0x20.
- NUM_PORTS=4, set pointer 0x50, read -> no PORT_CS; RSP_DATA=0xFF; ADDR_ERR=1; ERR_CLR clears it next cycle.
- Back-to-back reads with CMD_VALID held high from 0xFF -> accepts spaced 4 cycles apart; second read targets 0x00 (wrap).
- RESET pulsed in WAIT -> no RSP_VALID; all outputs at reset values; next read completes normally.
- STATUS_PTR_AUTOINC_EN undefined: two reads from 0x13 -> both strobe OFFSET_SEL=0x0008 on port 1; PTR stays 0x13.

Source files
------------

// File: rtl/status_reg_access_ctrl.sv
// Status register access sequencer: pointer decode, one-cycle bank strobe, read return with a valid pulse.
// Latency: write strobe 1 cycle after accept, read response 3 cycles after accept; cmd_ready only in IDLE.
// Build option STATUS_PTR_AUTOINC_EN: post-increment the pointer after every read or write.
module status_reg_access_ctrl #(
  parameter int NUM_PORTS = 4
) (
  input  logic                   i_sysclk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_type,
  input  logic [7:0]             i_cmd_data,
  output logic                   o_rsp_valid,
  output logic [7:0]             o_rsp_data,
  output logic [NUM_PORTS-1:0]   o_port_cs,
  output logic [15:0]            o_offset_sel,
  output logic                   o_rd_wr,
  output logic [7:0]             o_din_bus,
  input  logic [NUM_PORTS*8-1:0] i_port_dout,
  output logic [7:0]             o_ptr,
  output logic                   o_addr_err,
  input  logic                   i_err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] CMD_SET = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;
  localparam logic [4:0] NP5     = 5'(NUM_PORTS);

  state_t                 r_state;
  state_t                 w_next_state;

  logic [7:0]             r_ptr;
  logic                   r_is_rd;
  logic [3:0]             r_acc_port;
  logic                   r_acc_ok;
  logic                   r_err;
  logic                   r_rsp_valid;
  logic [7:0]             r_rsp_data;
  logic [NUM_PORTS-1:0]   r_port_cs;
  logic [15:0]            r_offset_sel;
  logic                   r_rd_wr;
  logic [7:0]             r_din;

  logic                   w_accept;
  logic                   w_is_access_cmd;
  logic                   w_port_ok;
  logic [NUM_PORTS-1:0]   w_cs_dec;
  logic [15:0]            w_off_dec;
  logic [7:0]             w_rd_byte;
  logic                   w_err_set;

  logic [NUM_PORTS-1:0]   w_cs_nxt;
  logic [15:0]            w_off_nxt;
  logic                   w_rd_wr_nxt;
  logic [7:0]             w_din_nxt;
  logic                   w_rsp_valid_nxt;

  assign w_accept        = i_cmd_valid && (r_state == ST_IDLE);
  assign w_is_access_cmd = (i_cmd_type == CMD_WR) || (i_cmd_type == CMD_RD);
  assign w_port_ok       = ({1'b0, r_ptr[7:4]} < NP5);
  assign w_off_dec       = 16'd1 << r_ptr[3:0];

  always_comb begin
    w_cs_dec = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cs_dec[k] = (r_ptr[7:4] == 4'(k));
    end
  end

  // Bank DOUT is registered, so it is sampled one cycle after the strobe.
  always_comb begin
    w_rd_byte = 8'hFF;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (r_acc_ok && (r_acc_port == 4'(k))) begin
        w_rd_byte = i_port_dout[8*k +: 8];
      end
    end
  end

  assign w_err_set = (w_accept && (i_cmd_type == CMD_RSV)) ||
                     ((r_state == ST_ACCESS) && !r_acc_ok);

  // FSM: state register
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_access_cmd) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: w_next_state = r_is_rd ? ST_WAIT : ST_IDLE;
      ST_WAIT:   w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs, computed one cycle ahead so every bus output is a flop
  always_comb begin
    w_cs_nxt        = '0;
    w_off_nxt       = '0;
    w_rd_wr_nxt     = 1'b1;
    w_din_nxt       = '0;
    w_rsp_valid_nxt = (r_state == ST_WAIT);
    if (w_accept && w_is_access_cmd) begin
      w_cs_nxt    = w_cs_dec;
      w_off_nxt   = w_off_dec;
      w_rd_wr_nxt = (i_cmd_type == CMD_RD);
      if (i_cmd_type == CMD_WR) begin
        w_din_nxt = i_cmd_data;
      end
    end
  end

  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_port_cs    <= '0;
      r_offset_sel <= '0;
      r_rd_wr      <= 1'b1;
      r_din        <= '0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_port_cs    <= w_cs_nxt;
      r_offset_sel <= w_off_nxt;
      r_rd_wr      <= w_rd_wr_nxt;
      r_din        <= w_din_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
    end
  end

  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr      <= '0;
      r_is_rd    <= 1'b0;
      r_acc_port <= '0;
      r_acc_ok   <= 1'b0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        case (i_cmd_type)
          CMD_SET: r_ptr <= i_cmd_data;
          CMD_WR, CMD_RD: begin
            r_is_rd    <= (i_cmd_type == CMD_RD);
            r_acc_port <= r_ptr[7:4];
            r_acc_ok   <= w_port_ok;
          end
          default: ;
        endcase
      end
`ifdef STATUS_PTR_AUTOINC_EN
      // Increments for dropped invalid-port accesses too; wraps 0xFF -> 0x00.
      if (r_state == ST_ACCESS) begin
        r_ptr <= r_ptr + 8'd1;
      end
`else
`endif
      if (r_state == ST_WAIT) begin
        r_rsp_data <= w_rd_byte;
      end
      r_err <= w_err_set || (r_err && !i_err_clr);
    end
  end

  assign o_cmd_ready  = (r_state == ST_IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_port_cs    = r_port_cs;
  assign o_offset_sel = r_offset_sel;
  assign o_rd_wr      = r_rd_wr;
  assign o_din_bus    = r_din;
  assign o_ptr        = r_ptr;
  assign o_addr_err   = r_err;

endmodule
